// File: rtl/uart_lite_ctrl.sv
// uart_lite_ctrl: sole AXI4-Lite master of an AXI UART Lite. Resets the UART FIFOs,
// polls STAT, and moves bytes between the UART FIFOs and the core's byte streams.
module uart_lite_ctrl #(
   parameter int unsigned POLL_GAP = 4
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [3:0]  uart_araddr,
   output logic        uart_arvalid,
   input  logic        uart_arready,
   input  logic [31:0] uart_rdata,
   input  logic [1:0]  uart_rresp,
   input  logic        uart_rvalid,
   output logic        uart_rready,
   output logic [3:0]  uart_awaddr,
   output logic        uart_awvalid,
   input  logic        uart_awready,
   output logic [31:0] uart_wdata,
   output logic [3:0]  uart_wstrb,
   output logic        uart_wvalid,
   input  logic        uart_wready,
   input  logic [1:0]  uart_bresp,
   input  logic        uart_bvalid,
   output logic        uart_bready,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        err_overrun,
   output logic        err_frame,
   output logic        err_resp,
   input  logic        err_clr
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_POLL   = 3'd1,
      S_DECIDE = 3'd2,
      S_RXRD   = 3'd3,
      S_TXWR   = 3'd4,
      S_GAP    = 3'd5
   } state_e;

   localparam logic [3:0] ADDR_RX   = 4'h0;
   localparam logic [3:0] ADDR_TX   = 4'h4;
   localparam logic [3:0] ADDR_STAT = 4'h8;
   localparam logic [3:0] ADDR_CTRL = 4'hC;
   localparam logic [3:0] GAP_LIM   = 4'(POLL_GAP);

   state_e      state_q, state_d;
   logic [3:0]  araddr_q, araddr_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic [3:0]  awaddr_q, awaddr_d;
   logic        awvalid_q, awvalid_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        wvalid_q, wvalid_d;
   logic        wr_pend_q, wr_pend_d;
   logic        bready_q, bready_d;
   logic        stat_rx_q, stat_rx_d;
   logic        stat_txf_q, stat_txf_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_ready_q, tx_ready_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        prio_q, prio_d;
   logic [3:0]  gap_q, gap_d;
   logic        err_ovr_q, err_ovr_d;
   logic        err_frm_q, err_frm_d;
   logic        err_rsp_q, err_rsp_d;

   logic        launch_rd_s, launch_wr_s;
   logic [3:0]  rd_addr_s, wr_addr_s;
   logic [31:0] wr_data_s;
   logic        rd_done_s, wr_done_s, aw_ok_s, w_ok_s;
   logic        stat_done_s, rx_load_s, tx_done_s, tx_load_s;
   logic        rx_cand_s, tx_cand_s;
   logic        unused_rdata_s;

   assign rd_done_s   = rready_q & uart_rvalid;
   assign wr_done_s   = bready_q & uart_bvalid;
   assign aw_ok_s     = ~awvalid_q | uart_awready;
   assign w_ok_s      = ~wvalid_q | uart_wready;
   assign stat_done_s = rd_done_s & (state_q == S_POLL);
   assign rx_load_s   = rd_done_s & (state_q == S_RXRD);
   assign tx_done_s   = wr_done_s & (state_q == S_TXWR);
   assign tx_load_s   = tx_valid & tx_ready_q;
   assign rx_cand_s   = stat_rx_q & ~rx_valid_q;
   assign tx_cand_s   = ~tx_ready_q & ~stat_txf_q;
   assign unused_rdata_s = ^uart_rdata[31:8];

   // Sequencer: picks the next access and requests its launch on the entering edge.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      gap_d       = gap_q;
      launch_rd_s = 1'b0;
      launch_wr_s = 1'b0;
      rd_addr_s   = ADDR_STAT;
      wr_addr_s   = ADDR_CTRL;
      wr_data_s   = 32'h0000_0000;
      case (state_q)
         S_INIT: begin
            if (~wr_pend_q & ~bready_q) begin
               launch_wr_s = 1'b1;
               wr_addr_s   = ADDR_CTRL;
               wr_data_s   = 32'h0000_0003;
            end else if (wr_done_s) begin
               state_d     = S_POLL;
               launch_rd_s = 1'b1;
            end else begin
               state_d = S_INIT;
            end
         end
         S_POLL: begin
            if (rd_done_s) begin
               state_d = S_DECIDE;
            end else begin
               state_d = S_POLL;
            end
         end
         S_DECIDE: begin
            if (rx_cand_s & (~tx_cand_s | ~prio_q)) begin
               state_d     = S_RXRD;
               launch_rd_s = 1'b1;
               rd_addr_s   = ADDR_RX;
            end else if (tx_cand_s) begin
               state_d     = S_TXWR;
               launch_wr_s = 1'b1;
               wr_addr_s   = ADDR_TX;
               wr_data_s   = {24'h00_0000, tx_byte_q};
            end else if (GAP_LIM == 4'd0) begin
               state_d     = S_POLL;
               launch_rd_s = 1'b1;
            end else begin
               state_d = S_GAP;
               gap_d   = 4'd0;
            end
         end
         S_RXRD: begin
            if (rd_done_s) begin
               state_d     = S_POLL;
               launch_rd_s = 1'b1;
               prio_d      = ~prio_q;
            end else begin
               state_d = S_RXRD;
            end
         end
         S_TXWR: begin
            if (wr_done_s) begin
               state_d     = S_POLL;
               launch_rd_s = 1'b1;
               prio_d      = ~prio_q;
            end else begin
               state_d = S_TXWR;
            end
         end
         S_GAP: begin
            gap_d = (gap_q == GAP_LIM) ? gap_q : gap_q + 4'd1;
            if (({1'b0, gap_q} + 5'd1) >= {1'b0, GAP_LIM}) begin
               state_d     = S_POLL;
               launch_rd_s = 1'b1;
            end else begin
               state_d = S_GAP;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // AXI channel registers: each valid is held until its own handshake.
   always_comb begin
      araddr_d  = launch_rd_s ? rd_addr_s : araddr_q;
      arvalid_d = launch_rd_s | (arvalid_q & ~uart_arready);
      rready_d  = (arvalid_q & uart_arready) | (rready_q & ~uart_rvalid);
      awaddr_d  = launch_wr_s ? wr_addr_s : awaddr_q;
      wdata_d   = launch_wr_s ? wr_data_s : wdata_q;
      awvalid_d = launch_wr_s | (awvalid_q & ~uart_awready);
      wvalid_d  = launch_wr_s | (wvalid_q & ~uart_wready);
      wr_pend_d = launch_wr_s | (wr_pend_q & ~(aw_ok_s & w_ok_s));
      // B is only accepted once both address and data have been taken.
      bready_d  = (wr_pend_q & aw_ok_s & w_ok_s) | (bready_q & ~uart_bvalid);
      if (launch_wr_s) begin
         wstrb_d = 4'hF;
      end else if (wr_done_s) begin
         wstrb_d = 4'h0;
      end else begin
         wstrb_d = wstrb_q;
      end
   end

   // Byte-stream buffers, captured STAT bits and sticky error flags.
   always_comb begin
      stat_rx_d  = stat_done_s ? uart_rdata[0] : stat_rx_q;
      stat_txf_d = stat_done_s ? uart_rdata[3] : stat_txf_q;
      tx_byte_d  = tx_load_s ? tx_data : tx_byte_q;
      if (tx_ready_q) begin
         tx_ready_d = ~tx_valid;
      end else begin
         tx_ready_d = tx_done_s;
      end
      rx_data_d  = rx_load_s ? uart_rdata[7:0] : rx_data_q;
      rx_valid_d = rx_load_s | (rx_valid_q & ~rx_ready);
      if (err_clr) begin
         err_ovr_d = 1'b0;
         err_frm_d = 1'b0;
         err_rsp_d = 1'b0;
      end else begin
         err_ovr_d = err_ovr_q | (stat_done_s & uart_rdata[5]);
         err_frm_d = err_frm_q | (stat_done_s & uart_rdata[6]);
         err_rsp_d = err_rsp_q | (rd_done_s & (uart_rresp != 2'b00))
                               | (wr_done_s & (uart_bresp != 2'b00));
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_INIT;
         araddr_q   <= 4'h0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         awaddr_q   <= 4'h0;
         awvalid_q  <= 1'b0;
         wdata_q    <= 32'h0000_0000;
         wstrb_q    <= 4'h0;
         wvalid_q   <= 1'b0;
         wr_pend_q  <= 1'b0;
         bready_q   <= 1'b0;
         stat_rx_q  <= 1'b0;
         stat_txf_q <= 1'b0;
         tx_byte_q  <= 8'h00;
         tx_ready_q <= 1'b1;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         prio_q     <= 1'b0;
         gap_q      <= 4'd0;
         err_ovr_q  <= 1'b0;
         err_frm_q  <= 1'b0;
         err_rsp_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arvalid_q  <= arvalid_d;
         rready_q   <= rready_d;
         awaddr_q   <= awaddr_d;
         awvalid_q  <= awvalid_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wvalid_q   <= wvalid_d;
         wr_pend_q  <= wr_pend_d;
         bready_q   <= bready_d;
         stat_rx_q  <= stat_rx_d;
         stat_txf_q <= stat_txf_d;
         tx_byte_q  <= tx_byte_d;
         tx_ready_q <= tx_ready_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         prio_q     <= prio_d;
         gap_q      <= gap_d;
         err_ovr_q  <= err_ovr_d;
         err_frm_q  <= err_frm_d;
         err_rsp_q  <= err_rsp_d;
      end
   end

   assign uart_araddr  = araddr_q;
   assign uart_arvalid = arvalid_q;
   assign uart_rready  = rready_q;
   assign uart_awaddr  = awaddr_q;
   assign uart_awvalid = awvalid_q;
   assign uart_wdata   = wdata_q;
   assign uart_wstrb   = wstrb_q;
   assign uart_wvalid  = wvalid_q;
   assign uart_bready  = bready_q;
   assign tx_ready     = tx_ready_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign err_overrun  = err_ovr_q;
   assign err_frame    = err_frm_q;
   assign err_resp     = err_rsp_q;

endmodule

// File: tb/tb_uart_lite_ctrl.sv
// Directed bench for uart_lite_ctrl: a small UART Lite slave responder with
// programmable STAT/RX values, ready delays and responses.
module tb_uart_lite_ctrl;
   localparam int POLL_GAP = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  uart_araddr;
   logic        uart_arvalid;
   logic        uart_arready = 1'b0;
   logic [31:0] uart_rdata = 32'h0;
   logic [1:0]  uart_rresp = 2'b00;
   logic        uart_rvalid = 1'b0;
   logic        uart_rready;
   logic [3:0]  uart_awaddr;
   logic        uart_awvalid;
   logic        uart_awready = 1'b0;
   logic [31:0] uart_wdata;
   logic [3:0]  uart_wstrb;
   logic        uart_wvalid;
   logic        uart_wready = 1'b0;
   logic [1:0]  uart_bresp = 2'b00;
   logic        uart_bvalid = 1'b0;
   logic        uart_bready;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        err_overrun, err_frame, err_resp;
   logic        err_clr = 1'b0;

   int          vectors = 0;
   int          miscompares = 0;

   // slave configuration and state
   logic [31:0] stat_val = 32'h0;
   logic [31:0] rxf_val = 32'h0;
   int          aw_wait = 0;
   int          w_wait = 0;
   logic [1:0]  bresp_v = 2'b00;
   int          aw_cnt, w_cnt;
   logic        r_pend, aw_got, w_got;
   logic [31:0] r_data_l;
   logic [3:0]  acc_log[$];

   always #5 clk = ~clk;

   uart_lite_ctrl #(.POLL_GAP(POLL_GAP)) dut (
      .clk(clk), .rstn(rstn),
      .uart_araddr(uart_araddr), .uart_arvalid(uart_arvalid), .uart_arready(uart_arready),
      .uart_rdata(uart_rdata), .uart_rresp(uart_rresp), .uart_rvalid(uart_rvalid),
      .uart_rready(uart_rready),
      .uart_awaddr(uart_awaddr), .uart_awvalid(uart_awvalid), .uart_awready(uart_awready),
      .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_wvalid(uart_wvalid),
      .uart_wready(uart_wready),
      .uart_bresp(uart_bresp), .uart_bvalid(uart_bvalid), .uart_bready(uart_bready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .err_overrun(err_overrun), .err_frame(err_frame), .err_resp(err_resp),
      .err_clr(err_clr)
   );

   // Slave bookkeeping on handshakes; logs every RX-FIFO read and TX-FIFO write in order.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
         r_data_l <= 32'h0;
      end else begin
         if (uart_arvalid && uart_arready) begin
            r_pend   <= 1'b1;
            r_data_l <= (uart_araddr == 4'h8) ? stat_val : rxf_val;
            if (uart_araddr == 4'h0) acc_log.push_back(4'h0);
         end
         if (uart_rvalid && uart_rready) r_pend <= 1'b0;
         if (uart_awvalid && uart_awready) begin
            aw_got <= 1'b1; aw_cnt <= 0;
            if (uart_awaddr == 4'h4) acc_log.push_back(4'h4);
         end else if (uart_awvalid) aw_cnt <= aw_cnt + 1;
         if (uart_wvalid && uart_wready) begin
            w_got <= 1'b1; w_cnt <= 0;
         end else if (uart_wvalid) w_cnt <= w_cnt + 1;
         if (uart_bvalid && uart_bready) begin
            aw_got <= 1'b0; w_got <= 1'b0;
         end
      end
   end

   // Slave drives its outputs on the falling edge.
   always @(negedge clk) begin
      uart_arready = uart_arvalid;
      uart_rvalid  = r_pend;
      uart_rdata   = r_pend ? r_data_l : 32'h0;
      uart_rresp   = 2'b00;
      uart_awready = uart_awvalid && (aw_cnt >= aw_wait);
      uart_wready  = uart_wvalid && (w_cnt >= w_wait);
      uart_bvalid  = aw_got && w_got;
      uart_bresp   = (aw_got && w_got) ? bresp_v : 2'b00;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for the next AR, then counts the cycles arvalid stays low before the following one.
   task automatic measure_poll_gap(output int n);
      int k;
      k = 0;
      while (!uart_arvalid && k < 50) begin @(negedge clk); k++; end
      n = 0;
      @(negedge clk);
      while (!uart_arvalid && n < 50) begin n++; @(negedge clk); end
   endtask

   task automatic wait_aw(input logic [3:0] addr, output int n);
      n = 0;
      while (!(uart_awvalid && uart_awaddr == addr) && n < 60) begin @(negedge clk); n++; end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      aw_wait = 2; w_wait = 0;
      repeat (3) @(negedge clk);
      chk("reset_valids", 32'({uart_arvalid, uart_rready, uart_awvalid, uart_wvalid, uart_bready, rx_valid}), 32'h0);
      chk("reset_tx_ready", 32'(tx_ready), 32'h1);
      chk("reset_regs", 32'({uart_awaddr, uart_araddr, uart_wstrb, rx_data}), 32'h0);
      chk("reset_wdata", uart_wdata, 32'h0);
      chk("reset_errs", 32'({err_overrun, err_frame, err_resp}), 32'h0);

      // INIT write: awready 2 extra cycles late, wready immediate
      rstn = 1'b1;
      @(negedge clk);
      chk("init_awaddr", 32'(uart_awaddr), 32'hC);
      chk("init_wdata", uart_wdata, 32'h3);
      chk("init_wstrb", 32'(uart_wstrb), 32'hF);
      chk("init_c1_aw_w_b", 32'({uart_awvalid, uart_wvalid, uart_bready}), 32'b110);
      @(negedge clk);
      chk("init_c2_aw_w_b", 32'({uart_awvalid, uart_wvalid, uart_bready}), 32'b100);
      @(negedge clk);
      chk("init_c3_aw_w_b", 32'({uart_awvalid, uart_wvalid, uart_bready}), 32'b100);
      @(negedge clk);
      chk("init_c4_aw_w_b", 32'({uart_awvalid, uart_wvalid, uart_bready}), 32'b001);
      @(negedge clk);
      chk("first_poll", 32'({uart_arvalid, uart_araddr, uart_bready}), 32'({1'b1, 4'h8, 1'b0}));
      aw_wait = 0;

      // idle polling spacing
      measure_poll_gap(n);
      chk("poll_spacing", 32'(n), 32'(POLL_GAP + 2));

      // RX path: STAT.0 set at this poll, byte appears 5 cycles after the poll AR
      stat_val = 32'h01; rxf_val = 32'h5A; acc_log.delete();
      repeat (4) @(negedge clk);
      chk("rx_latency_early", 32'(rx_valid), 32'h0);
      @(negedge clk);
      chk("rx_valid", 32'(rx_valid), 32'h1);
      chk("rx_data", 32'(rx_data), 32'h5A);
      repeat (40) @(negedge clk);
      chk("rx_backpressure_reads", 32'(acc_log.size()), 32'h1);
      chk("rx_held", 32'({rx_valid, rx_data}), 32'h15A);
      stat_val = 32'h00;
      repeat (12) @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk("rx_consumed", 32'(rx_valid), 32'h0);
      repeat (20) @(negedge clk);
      chk("rx_no_reread", 32'(acc_log.size()), 32'h1);

      // TX path
      acc_log.delete();
      tx_data = 8'hA5; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("tx_loaded", 32'(tx_ready), 32'h0);
      wait_aw(4'h4, n);
      chk("tx_aw_seen", 32'(n < 60), 32'h1);
      chk("tx_wdata", uart_wdata, 32'h0000_00A5);
      chk("tx_wstrb_wvalid", 32'({uart_wstrb, uart_wvalid}), 32'h1F);
      @(negedge clk);
      chk("tx_b_phase", 32'({uart_bready, tx_ready}), 32'b10);
      @(negedge clk);
      chk("tx_ready_after_b", 32'(tx_ready), 32'h1);

      // TX FIFO full: polls only, then the write once STAT.3 clears
      stat_val = 32'h08;
      repeat (12) @(negedge clk);
      acc_log.delete();
      tx_data = 8'h3C; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      measure_poll_gap(n);
      chk("txfull_poll_spacing", 32'(n), 32'(POLL_GAP + 2));
      repeat (30) @(negedge clk);
      chk("txfull_no_write", 32'(acc_log.size()), 32'h0);
      chk("txfull_held", 32'(tx_ready), 32'h0);
      stat_val = 32'h00;
      wait_aw(4'h4, n);
      chk("txfull_released", 32'(n < 60), 32'h1);
      chk("txfull_wdata", uart_wdata, 32'h0000_003C);
      repeat (3) @(negedge clk);

      // reset in the middle of a read
      n = 0;
      while (!uart_arvalid && n < 50) begin @(negedge clk); n++; end
      rstn = 1'b0;
      #1;
      chk("midreset_valids", 32'({uart_arvalid, uart_rready, uart_awvalid, uart_wvalid, uart_bready}), 32'h0);
      chk("midreset_tx_ready", 32'(tx_ready), 32'h1);

      // fairness: RX and TX both always available, RX first after reset
      @(negedge clk);
      stat_val = 32'h01; rxf_val = 32'h11; tx_data = 8'h77; tx_valid = 1'b1; rx_ready = 1'b1;
      acc_log.delete();
      @(negedge clk);
      rstn = 1'b1;
      n = 0;
      while (acc_log.size() < 4 && n < 200) begin @(negedge clk); n++; end
      chk("fair_count", 32'(acc_log.size() >= 4), 32'h1);
      if (acc_log.size() >= 4) begin
         chk("fair_0", 32'(acc_log[0]), 32'h0);
         chk("fair_1", 32'(acc_log[1]), 32'h4);
         chk("fair_2", 32'(acc_log[2]), 32'h0);
         chk("fair_3", 32'(acc_log[3]), 32'h4);
      end
      tx_valid = 1'b0;

      // sticky errors
      stat_val = 32'h60;
      repeat (15) @(negedge clk);
      chk("err_stat", 32'({err_overrun, err_frame, err_resp}), 32'b110);
      bresp_v = 2'd2;
      tx_data = 8'h42; tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 60) begin @(negedge clk); n++; end
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("err_bresp", 32'(err_resp), 32'h1);
      bresp_v = 2'd0;
      n = 0;
      while (!(uart_rready && uart_araddr == 4'h8) && n < 60) begin @(negedge clk); n++; end
      chk("clr_poll_seen", 32'(n < 60), 32'h1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr_wins", 32'({err_overrun, err_frame, err_resp}), 32'b000);
      repeat (12) @(negedge clk);
      chk("err_reset_after_clr", 32'({err_overrun, err_frame, err_resp}), 32'b110);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
